// File: rtl/sat_fifo_pkg.sv
// Shared definitions for the clause FIFO path: controller state encoding,
// default batch geometry and the mask popcount used by the clause evaluator.
package sat_fifo_pkg;

  localparam int CC_DEF = 20;
  localparam int CW_DEF = 9;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WRITE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_CLEAR  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Counts set bits among the low n bits of v (n <= 64).
  function automatic int unsigned popcount(input logic [63:0] v, input int unsigned n);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < n && v[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/fifo_tree_ctrl_if.sv
// Batch intake and clause drain handshakes of fifo_tree_ctrl.
// master = controller side, slave = upstream evaluator / downstream selector side.
interface fifo_tree_ctrl_if #(
  parameter int CLAUSE_COUNT = 20,
  parameter int CLAUSE_WIDTH = 9
);
  logic                                 batch_valid_i;
  logic                                 batch_ready_o;
  logic [CLAUSE_WIDTH*CLAUSE_COUNT-1:0] batch_clauses_i;
  logic [CLAUSE_COUNT-1:0]              batch_mask_i;
  logic                                 clause_valid_o;
  logic                                 clause_ready_i;
  logic [CLAUSE_WIDTH-1:0]              clause_o;

  modport master (
    input  batch_valid_i, batch_clauses_i, batch_mask_i, clause_ready_i,
    output batch_ready_o, clause_valid_o, clause_o
  );

  modport slave (
    output batch_valid_i, batch_clauses_i, batch_mask_i, clause_ready_i,
    input  batch_ready_o, clause_valid_o, clause_o
  );
endinterface

// File: rtl/fifo_tree_ctrl_out.sv
// fifo_tree_out_reg: one-entry output register for clauses read from the tree,
// tracking the read issued last cycle whose data arrives this cycle.
module fifo_tree_out_reg #(
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rden,
  input  logic [CW-1:0] ft_clause,
  input  logic          ready,
  output logic          rd_pend,
  output logic          out_vld,
  output logic [CW-1:0] out_data,
  output logic          xfer
);

  logic          vld_p1;
  logic          vld_p2;
  logic [CW-1:0] data_p2;

  assign rd_pend  = vld_p1;
  assign out_vld  = vld_p2;
  assign out_data = data_p2;
  assign xfer     = vld_p2 & ready;

  // p1: read in flight; p2: tree data captured, held until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else begin
      vld_p1 <= rden;
      if (vld_p1) begin
        data_p2 <= ft_clause;
        vld_p2  <= 1'b1;
      end else if (xfer) begin
        vld_p2 <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fifo_tree_ctrl.sv
// Sequencer that writes one clause batch into FIFO_tree and drains it over valid/ready.
// Optional drain watchdog: define FT_DRAIN_WATCHDOG_EN.
module fifo_tree_ctrl
  import sat_fifo_pkg::*;
#(
  parameter int CLAUSE_COUNT  = CC_DEF,
  parameter int CLAUSE_WIDTH  = CW_DEF,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 5,
  parameter int WDOG_CYCLES   = 256
) (
  input  logic                                 clk,
  input  logic                                 reset,
  fifo_tree_ctrl_if.master                     bus,
  output logic [CLAUSE_WIDTH*CLAUSE_COUNT-1:0] ft_clauses_o,
  output logic [CLAUSE_COUNT-1:0]              ft_valid_o,
  output logic                                 ft_wren_o,
  output logic                                 ft_rden_o,
  output logic                                 ft_cOF_o,
  input  logic                                 ft_empty_i,
  input  logic                                 ft_OF_i,
  input  logic [CLAUSE_WIDTH-1:0]              ft_clause_i,
  output logic                                 batch_done_o,
  output logic                                 sat_found_o,
  output logic                                 overflow_o,
  output logic [CNT_W-1:0]                     drained_count_o
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  if (((1 << CNT_W) <= CLAUSE_COUNT) || (SETTLE_CYCLES < 1) || (WDOG_CYCLES < 1)) begin : g_bad_cfg
    $error("fifo_tree_ctrl: invalid CNT_W / SETTLE_CYCLES / WDOG_CYCLES");
  end

  logic [2:0]       state;
  logic [CNT_W-1:0] expected;
  logic [CNT_W-1:0] issued;
  logic [SW-1:0]    settle_cnt;
  logic             of_flag;
  logic             clear_armed;
  logic             rd_pend;
  logic             xfer;
  logic             accept;
  logic             drain_last;
  logic             ovf_exit;
  logic             go_clear;
  logic             wdog_hit;
  logic             wdog_fire;

  fifo_tree_out_reg #(.CW(CLAUSE_WIDTH)) u_out (
    .clk      (clk),
    .rst      (reset),
    .rden     (ft_rden_o),
    .ft_clause(ft_clause_i),
    .ready    (bus.clause_ready_i),
    .rd_pend  (rd_pend),
    .out_vld  (bus.clause_valid_o),
    .out_data (bus.clause_o),
    .xfer     (xfer)
  );

  assign bus.batch_ready_o = (state == ST_IDLE);
  assign accept            = bus.batch_valid_i & bus.batch_ready_o;
  assign ft_wren_o         = (state == ST_WRITE);
  assign ft_cOF_o          = (state == ST_CLEAR);
  assign batch_done_o      = (state == ST_DONE);

  assign ft_rden_o = (state == ST_DRAIN) & ~clear_armed & ~ft_empty_i & ~rd_pend &
                     (~bus.clause_valid_o | bus.clause_ready_i) & (issued < expected);

  // Once overflow is seen the popcount is no longer trusted; only sustained empty ends the drain.
  assign drain_last = ~of_flag & xfer & ((drained_count_o + CNT_W'(1)) == expected);
  assign ovf_exit   = of_flag & ~clear_armed & (settle_cnt == SW'(SETTLE_CYCLES)) &
                      ~rd_pend & ~bus.clause_valid_o;
  assign go_clear   = clear_armed & ~rd_pend & (~bus.clause_valid_o | xfer);

`ifdef FT_DRAIN_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_cnt;

  assign wdog_fire = ((state == ST_SETTLE) | (state == ST_DRAIN)) & ~xfer &
                     (wdog_cnt == WW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      wdog_cnt <= '0;
      wdog_hit <= 1'b0;
    end else if ((state == ST_SETTLE) || (state == ST_DRAIN)) begin
      wdog_cnt <= (xfer || wdog_fire) ? '0 : wdog_cnt + WW'(1);
      if (wdog_fire) wdog_hit <= 1'b1;
    end else begin
      wdog_cnt <= '0;
    end
  end
`else
  assign wdog_fire = 1'b0;
  assign wdog_hit  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      ft_clauses_o    <= '0;
      ft_valid_o      <= '0;
      expected        <= '0;
      issued          <= '0;
      drained_count_o <= '0;
      overflow_o      <= 1'b0;
      of_flag         <= 1'b0;
      clear_armed     <= 1'b0;
      settle_cnt      <= '0;
      sat_found_o     <= 1'b0;
    end else begin
      sat_found_o <= 1'b0;
      if (ft_rden_o) issued <= issued + CNT_W'(1);
      if (xfer) drained_count_o <= drained_count_o + CNT_W'(1);
      if (ft_OF_i && (state != ST_IDLE)) begin
        overflow_o  <= 1'b1;
        of_flag     <= 1'b1;
        clear_armed <= 1'b1;
      end
      if (wdog_fire) overflow_o <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            ft_clauses_o    <= bus.batch_clauses_i;
            ft_valid_o      <= bus.batch_mask_i;
            expected        <= CNT_W'(popcount(64'(bus.batch_mask_i), CLAUSE_COUNT));
            issued          <= '0;
            drained_count_o <= '0;
            overflow_o      <= 1'b0;
            of_flag         <= 1'b0;
            clear_armed     <= 1'b0;
            settle_cnt      <= '0;
            if (bus.batch_mask_i == '0) begin
              sat_found_o <= 1'b1;
              state       <= ST_DONE;
            end else begin
              state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: state <= ST_SETTLE;
        ST_SETTLE: begin
          if (wdog_fire) begin
            state <= ST_CLEAR;
          end else if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            settle_cnt <= '0;
            state      <= ST_DRAIN;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        ST_DRAIN: begin
          // settle_cnt now measures the current run of consecutive empty cycles
          if (!ft_empty_i) settle_cnt <= '0;
          else if (settle_cnt != SW'(SETTLE_CYCLES)) settle_cnt <= settle_cnt + SW'(1);
          if (wdog_fire) state <= ST_CLEAR;
          else if (drain_last || ovf_exit) state <= ST_DONE;
          else if (go_clear) state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          clear_armed <= 1'b0;
          settle_cnt  <= '0;
          state       <= wdog_hit ? ST_DONE : ST_DRAIN;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
